// File: rtl/aq_djpeg_pkg.sv
//------------------------------------------------------------------------------
// Module : aq_djpeg_pkg
// Brief  : Shared types and constants for the DJPEG pixel writer
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package aq_djpeg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } wr_state_t;

  localparam logic [7:0] c_ALPHA_OPAQUE = 8'hFF;

  // Byte offset of pixel (x,y): 32-bit row product plus 4-byte pixel pitch.
  function automatic logic [33:0] pixelOffset(input logic [15:0] x,
                                              input logic [15:0] y,
                                              input logic [15:0] stride);
    logic [31:0] prod;
    prod = {16'd0, y} * {16'd0, stride};
    return {2'b00, prod} + {16'd0, x, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aq_djpeg_pixel_wr_if.sv
//------------------------------------------------------------------------------
// Module : aq_djpeg_pixel_wr_if
// Brief  : Pixel input stream and memory write request channel
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface aq_djpeg_pixel_wr_if #(
  parameter int ADDR_W = 32
);
  logic              InEnable;
  logic [15:0]       InPixelX;
  logic [15:0]       InPixelY;
  logic [7:0]        InR;
  logic [7:0]        InG;
  logic [7:0]        InB;
  logic              InReady;
  logic              WrValid;
  logic              WrReady;
  logic [ADDR_W-1:0] WrAddr;
  logic [31:0]       WrData;

  // slave: the pixel writer; master: converter upstream plus memory downstream
  modport slave (
    input  InEnable, InPixelX, InPixelY, InR, InG, InB, WrReady,
    output InReady, WrValid, WrAddr, WrData
  );

  modport master (
    output InEnable, InPixelX, InPixelY, InR, InG, InB, WrReady,
    input  InReady, WrValid, WrAddr, WrData
  );
endinterface

`default_nettype wire

// File: rtl/aq_djpeg_pixel_fifo.sv
//------------------------------------------------------------------------------
// Module : aq_djpeg_pixel_fifo
// Brief  : Synchronous count-based FIFO; output reads zero while empty
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aq_djpeg_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] pushData,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] popData,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign full     = (r_count == c_FULL);
  assign empty    = (r_count == '0);
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;
  assign popData  = empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

endmodule

`default_nettype wire

// File: rtl/aq_djpeg_pixel_wr.sv
//------------------------------------------------------------------------------
// Module : aq_djpeg_pixel_wr
// Brief  : Turns the RGB pixel stream into 32-bit ARGB memory writes.
//          Define AQ_DJPEG_PIXEL_WR_CROP_EN to drop MCU padding pixels.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aq_djpeg_pixel_wr
  import aq_djpeg_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              Start,
  input  wire logic [ADDR_W-1:0] Base,
  input  wire logic [15:0]       Stride,
  input  wire logic [15:0]       Width,
  input  wire logic [15:0]       Height,
  aq_djpeg_pixel_wr_if.slave     bus,
  output logic                   Busy,
  output logic                   Done
);

  localparam int ENTRY_W = ADDR_W + 33;

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_stride;
  logic [15:0]       r_width;
  logic [15:0]       r_height;

  logic               w_accept;
  logic               w_push;
  logic               w_last;
  logic [ADDR_W-1:0]  w_addr;
  logic [ENTRY_W-1:0] w_pushData;
  logic [ENTRY_W-1:0] w_popData;
  logic               w_popLast;
  logic               w_full;
  logic               w_empty;
  logic               w_wrFire;
  logic               w_frameEnd;

  assign w_accept = bus.InEnable && bus.InReady;

`ifdef AQ_DJPEG_PIXEL_WR_CROP_EN
  logic w_inFrame;
  assign w_inFrame = (bus.InPixelX < r_width) && (bus.InPixelY < r_height);
  assign w_push    = w_accept && w_inFrame;
`else
  assign w_push    = w_accept;
`endif

  // r_width/r_height are non-zero whenever pixels can be accepted
  assign w_last = (bus.InPixelX == r_width - 16'd1) &&
                  (bus.InPixelY == r_height - 16'd1);
  assign w_addr = r_base + ADDR_W'(pixelOffset(bus.InPixelX, bus.InPixelY, r_stride));
  assign w_pushData = {w_last, w_addr, c_ALPHA_OPAQUE, bus.InR, bus.InG, bus.InB};

  assign bus.InReady = (r_state == ST_RUN) && !w_full;
  assign bus.WrValid = !w_empty;
  assign {w_popLast, bus.WrAddr, bus.WrData} = w_popData;

  assign w_wrFire   = bus.WrValid && bus.WrReady;
  // Anything queued behind the final pixel belongs to no frame; drop it.
  assign w_frameEnd = w_wrFire && w_popLast;

  aq_djpeg_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (w_frameEnd),
    .push     (w_push),
    .pushData (w_pushData),
    .pop      (bus.WrReady),
    .popData  (w_popData),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_stride <= '0;
      r_width  <= '0;
      r_height <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_base   <= Base;
            r_stride <= Stride;
            r_width  <= Width;
            r_height <= Height;
            if ((Width == 16'd0) || (Height == 16'd0)) begin
              Done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              Busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_frameEnd) begin
            r_state <= ST_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aq_djpeg_pixel_wr.sv
//------------------------------------------------------------------------------
// Module : tb_aq_djpeg_pixel_wr
// Brief  : Randomized bench for aq_djpeg_pixel_wr against a queue-based model
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aq_djpeg_pixel_wr;

  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 32;
`ifdef AQ_DJPEG_PIXEL_WR_CROP_EN
  localparam bit CROP = 1'b1;
`else
  localparam bit CROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] Base = '0;
  logic [15:0] Stride = '0;
  logic [15:0] Width = '0;
  logic [15:0] Height = '0;
  logic        Busy;
  logic        Done;

  aq_djpeg_pixel_wr_if #(.ADDR_W(ADDR_W)) bus ();

  aq_djpeg_pixel_wr #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .Base   (Base),
    .Stride (Stride),
    .Width  (Width),
    .Height (Height),
    .bus    (bus),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pix_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  pix_t src[$];
  wr_t  expQ[$];

  int nVec = 0;
  int nErr = 0;

  // model state: the frame as the spec describes it, not the RTL registers
  bit          mRun = 1'b0;
  bit          doneExp = 1'b0;
  logic [31:0] mBase = '0;
  logic [15:0] mStride = '0;
  logic [15:0] mW = '0;
  logic [15:0] mH = '0;

  int          wrCount = 0;
  int          acceptCount = 0;
  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  logic [31:0] lastWrAddr = '0;
  int          wrMode = 0;
  bit          fullRate = 1'b1;
  bit          inWasAccepted = 1'b0;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic pix_t mkPix(input int x, input int y);
    pix_t p;
    p.x = 16'(x);
    p.y = 16'(y);
    p.r = 8'($urandom);
    p.g = 8'($urandom);
    p.b = 8'($urandom);
    return p;
  endfunction

  // One clock: check/advance the model at negedge, drive inputs 1 after posedge.
  task automatic tick();
    wr_t  w;
    pix_t p;
    bit   lastPop;
    bit   wasRun;
    @(negedge clk);
    if (!rst) begin
      expQ.delete();
      mRun = 0; doneExp = 0;
      mBase = '0; mStride = '0; mW = '0; mH = '0;
    end
    checkVal("Done", Done, doneExp);
    checkVal("Busy", Busy, mRun);
    checkVal("InReady", bus.InReady, mRun && (expQ.size() < FIFO_DEPTH));
    checkVal("WrValid", bus.WrValid, expQ.size() != 0);
    doneExp = 0;
    inWasAccepted = 0;
    if (rst) begin
      lastPop = 0;
      wasRun  = mRun;
      if (bus.WrValid && bus.WrReady) begin
        wrCount++;
        obsAddr.push_back(bus.WrAddr);
        obsData.push_back(bus.WrData);
        lastWrAddr = bus.WrAddr;
        if (expQ.size() == 0) begin
          checkVal("WrUnexpected", bus.WrValid, 1'b0);
        end else begin
          w = expQ.pop_front();
          checkVal("WrAddr", bus.WrAddr, w.addr);
          checkVal("WrData", bus.WrData, w.data);
          lastPop = w.last;
        end
      end
      if (bus.InEnable && bus.InReady && src.size() != 0) begin
        inWasAccepted = 1;
        acceptCount++;
        p = src[0];
        if (!(CROP && (p.x >= mW || p.y >= mH))) begin
          w.addr = mBase + 32'(p.y) * 32'(mStride) + 32'(p.x) * 32'd4;
          w.data = {8'hFF, p.r, p.g, p.b};
          w.last = (p.x == mW - 16'd1) && (p.y == mH - 16'd1);
          expQ.push_back(w);
        end
      end
      if (lastPop) begin
        mRun = 0;
        doneExp = 1;
        expQ.delete();
      end
      if (Start && !wasRun) begin
        mBase = Base; mStride = Stride; mW = Width; mH = Height;
        if (Width == 0 || Height == 0) doneExp = 1;
        else mRun = 1;
      end
    end
    @(posedge clk);
    #1;
    Start = 1'b0;
    if (inWasAccepted) void'(src.pop_front());
    if (src.size() == 0) bus.InEnable = 1'b0;
    else if (!(bus.InEnable && !inWasAccepted)) bus.InEnable = fullRate || ($urandom % 4 != 0);
    if (src.size() != 0) begin
      bus.InPixelX = src[0].x;
      bus.InPixelY = src[0].y;
      bus.InR = src[0].r;
      bus.InG = src[0].g;
      bus.InB = src[0].b;
    end
    bus.WrReady = (wrMode == 0) ? 1'b1 : (wrMode == 1) ? ($urandom % 3 != 0) : 1'b0;
  endtask

  task automatic startFrame(input logic [31:0] b, input logic [15:0] s,
                            input logic [15:0] w, input logic [15:0] h);
    Base = b; Stride = s; Width = w; Height = h;
    Start = 1'b1;
    tick();
    // only the latched copy may matter from here on
    Base = $urandom; Stride = 16'($urandom); Width = 16'($urandom); Height = 16'($urandom);
  endtask

  task automatic runFrame(input int maxCyc);
    int n = 0;
    while ((mRun || src.size() != 0 || expQ.size() != 0 || doneExp) && n < maxCyc) begin
      tick();
      n++;
    end
    if (n >= maxCyc) checkVal("FrameTimeout", 64'(n), 64'(maxCyc - 1));
    tick();
  endtask

  initial begin
    int n;
    int w;
    int h;
    bus.InEnable = 1'b0; bus.InPixelX = '0; bus.InPixelY = '0;
    bus.InR = '0; bus.InG = '0; bus.InB = '0; bus.WrReady = 1'b1;

    // reset state
    repeat (3) tick();
    checkVal("RstWrAddr", bus.WrAddr, 32'h0);
    checkVal("RstWrData", bus.WrData, 32'h0);
    rst = 1'b1;
    tick();

    // address/data formation for pixel (3,2)
    wrMode = 0; fullRate = 1;
    obsAddr.delete(); obsData.delete(); wrCount = 0;
    src.push_back('{x: 16'd3, y: 16'd2, r: 8'h12, g: 8'h34, b: 8'h56});
    src.push_back(mkPix(15, 15));
    startFrame(32'h1000, 16'd64, 16'd16, 16'd16);
    runFrame(100);
    checkVal("Pix32Count", 64'(wrCount), 64'd2);
    if (obsAddr.size() != 0) begin
      checkVal("Pix32Addr", obsAddr[0], 32'h108C);
      checkVal("Pix32Data", obsData[0], 32'hFF123456);
    end

    // write back-pressure at full pixel rate
    wrMode = 2; fullRate = 1; wrCount = 0; acceptCount = 0;
    for (int i = 0; i < 30; i++) src.push_back(mkPix(i % 16, i / 16));
    src.push_back(mkPix(15, 15));
    startFrame(32'h4000, 16'd64, 16'd16, 16'd16);
    repeat (20) tick();
    checkVal("StallAccepted", 64'(acceptCount), 64'(FIFO_DEPTH));
    checkVal("StallInReady", bus.InReady, 1'b0);
    checkVal("StallWrites", 64'(wrCount), 64'd0);
    wrMode = 1;
    runFrame(1000);
    checkVal("StallTotalWrites", 64'(wrCount), 64'd31);

    // 20x20 frame delivered as 4:2:0 MCUs, (19,19) placed last
    wrMode = 1; fullRate = 0; wrCount = 0;
    for (int my = 0; my < 2; my++)
      for (int mx = 0; mx < 2; mx++)
        for (int py = 0; py < 16; py++)
          for (int px = 0; px < 16; px++)
            if (!((mx * 16 + px) == 19 && (my * 16 + py) == 19))
              src.push_back(mkPix(mx * 16 + px, my * 16 + py));
    src.push_back(mkPix(19, 19));
    startFrame(32'h2000_0000, 16'd96, 16'd20, 16'd20);
    runFrame(20000);
    checkVal("McuWrites", 64'(wrCount), CROP ? 64'd400 : 64'd1024);
    checkVal("McuLastAddr", lastWrAddr, 32'h2000_0000 + 32'd19 * 32'd96 + 32'd76);
    checkVal("McuBusyAfter", Busy, 1'b0);

    // zero-sized frames
    wrCount = 0;
    startFrame(32'h8000, 16'd16, 16'd8, 16'd0);
    runFrame(20);
    startFrame(32'h8000, 16'd16, 16'd0, 16'd5);
    runFrame(20);
    checkVal("ZeroWrites", 64'(wrCount), 64'd0);

    // reset with pixels buffered
    wrMode = 2; fullRate = 1; acceptCount = 0; wrCount = 0;
    for (int i = 0; i < 10; i++) src.push_back(mkPix(i, 0));
    startFrame(32'h0, 16'd64, 16'd16, 16'd16);
    n = 0;
    while (acceptCount < 5 && n < 50) begin tick(); n++; end
    checkVal("BufferedBeforeRst", 64'(acceptCount), 64'd5);
    rst = 1'b0;
    tick();
    checkVal("RstMidWrAddr", bus.WrAddr, 32'h0);
    checkVal("RstMidWrData", bus.WrData, 32'h0);
    rst = 1'b1;
    wrMode = 1;
    repeat (12) tick();
    src.delete();
    tick();
    checkVal("RstNoWrites", 64'(wrCount), 64'd0);
    src.push_back(mkPix(0, 0));
    src.push_back(mkPix(1, 0));
    startFrame(32'h100, 16'd8, 16'd2, 16'd1);
    runFrame(100);
    checkVal("PostRstWrites", 64'(wrCount), 64'd2);

    // random small frames, with an ignored Start mid-frame
    for (int f = 0; f < 6; f++) begin
      wrMode = 1; fullRate = 0; wrCount = 0;
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 6);
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          src.push_back(mkPix(x, y));
      startFrame({$urandom, 2'b00}, 16'($urandom), 16'(w), 16'(h));
      repeat (2) tick();
      if (mRun) begin
        Width = 16'd1; Height = 16'd1; Start = 1'b1;
      end
      runFrame(1000);
      checkVal("RandWrites", 64'(wrCount), 64'(w * h));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

`default_nettype wire
